// File: rtl/prio_enc_stream.sv
// Serialising priority encoder: captures an N-bit request vector and emits the
// index of each set bit, one per beat, with per-burst popcount and one-hot flag.
module prio_enc_stream #(
   parameter int N         = 8,
   parameter bit LSB_FIRST = 1'b1,
   localparam int W        = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [N-1:0] in_vec,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [W-1:0] out_idx,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         out_last,
   output logic         out_single,
   output logic [W:0]   out_count
);

   typedef enum logic {
      IDLE,
      BURST
   } state_t;

   state_t       state_q, state_d;
   logic [N-1:0] pending_q, pending_d;
   logic [W:0]   count_q, count_d;
   logic         single_q, single_d;

   logic [W:0]   vec_cnt;
   logic         found;
   int unsigned  j;

   always_comb begin
      vec_cnt = '0;
      for (int unsigned i = 0; i < N; i++) begin
         vec_cnt = vec_cnt + (W+1)'(in_vec[i]);
      end
   end

   // Scan in priority order; the first hit wins.
   always_comb begin
      out_idx = '0;
      found   = 1'b0;
      j       = 0;
      for (int unsigned i = 0; i < N; i++) begin
         j = LSB_FIRST ? i : (N - 1 - i);
         if (!found && pending_q[j]) begin
            out_idx = W'(j);
            found   = 1'b1;
         end
      end
   end

   always_comb begin
      out_valid  = (state_q == BURST);
      out_last   = (pending_q != '0) && ((pending_q & (pending_q - N'(1))) == '0);
      out_single = single_q;
      out_count  = count_q;
      in_ready   = rst_n & ((state_q == IDLE) | (out_valid & out_ready & out_last));

      state_d   = state_q;
      pending_d = pending_q;
      count_d   = count_q;
      single_d  = single_q;

      if (out_valid && out_ready) begin
         pending_d[out_idx] = 1'b0;
         if (out_last) begin
            state_d = IDLE;
         end
      end

      // A zero vector is consumed but leaves the burst registers untouched.
      if (in_valid && in_ready && (in_vec != '0)) begin
         pending_d = in_vec;
         count_d   = vec_cnt;
         single_d  = (vec_cnt == (W+1)'(1));
         state_d   = BURST;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         pending_q <= '0;
         count_q   <= '0;
         single_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         count_q   <= count_d;
         single_q  <= single_d;
      end
   end

endmodule

// File: tb/tb_prio_enc_stream.sv
// Bench for prio_enc_stream: two instances (LSB-first and MSB-first) share
// stimulus; a queue-based model is compared every cycle plus directed literals.
module tb_prio_enc_stream;

   logic       clk;
   logic       rst_n;
   logic [7:0] in_vec;
   logic       in_valid;
   logic       out_ready;

   logic       l_in_ready, l_out_valid, l_out_last, l_out_single;
   logic [2:0] l_out_idx;
   logic [3:0] l_out_count;
   logic       m_in_ready, m_out_valid, m_out_last, m_out_single;
   logic [2:0] m_out_idx;
   logic [3:0] m_out_count;

   int checks   = 0;
   int failures = 0;

   prio_enc_stream #(.N(8), .LSB_FIRST(1'b1)) u_lsb (
      .clk(clk), .rst_n(rst_n), .in_vec(in_vec), .in_valid(in_valid),
      .in_ready(l_in_ready), .out_idx(l_out_idx), .out_valid(l_out_valid),
      .out_ready(out_ready), .out_last(l_out_last), .out_single(l_out_single),
      .out_count(l_out_count)
   );

   prio_enc_stream #(.N(8), .LSB_FIRST(1'b0)) u_msb (
      .clk(clk), .rst_n(rst_n), .in_vec(in_vec), .in_valid(in_valid),
      .in_ready(m_in_ready), .out_idx(m_out_idx), .out_valid(m_out_valid),
      .out_ready(out_ready), .out_last(m_out_last), .out_single(m_out_single),
      .out_count(m_out_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: each burst is the ordered list of beat indices still to emit.
   int mq_l[$];
   int mq_m[$];
   int mcnt_l, mcnt_m, msgl_l, msgl_m;

   function automatic logic exp_ready(input int sz);
      return rst_n && ((sz == 0) || (out_ready && sz == 1));
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mq_l.delete();
         mq_m.delete();
         mcnt_l = 0; mcnt_m = 0; msgl_l = 0; msgl_m = 0;
      end else begin
         logic rl, rm;
         int   pc;
         rl = exp_ready(mq_l.size());
         rm = exp_ready(mq_m.size());
         if (mq_l.size() > 0 && out_ready) void'(mq_l.pop_front());
         if (mq_m.size() > 0 && out_ready) void'(mq_m.pop_front());
         pc = 0;
         for (int i = 0; i < 8; i++) if (in_vec[i]) pc++;
         if (in_valid && rl && pc != 0) begin
            mq_l.delete();
            for (int i = 0; i < 8; i++) if (in_vec[i]) mq_l.push_back(i);
            mcnt_l = pc;
            msgl_l = (pc == 1) ? 1 : 0;
         end
         if (in_valid && rm && pc != 0) begin
            mq_m.delete();
            for (int i = 0; i < 8; i++) if (in_vec[i]) mq_m.push_front(i);
            mcnt_m = pc;
            msgl_m = (pc == 1) ? 1 : 0;
         end
      end
   end

   task automatic cmp_dut(input string who, input logic ov, input logic ir,
                          input logic [2:0] idx, input logic last, input logic sgl,
                          input logic [3:0] cnt, input int sz, input int front,
                          input int ecnt, input int esgl);
      chk({who, "_out_valid"}, ov, (sz > 0) ? 1 : 0);
      chk({who, "_in_ready"}, ir, exp_ready(sz));
      if (sz > 0) begin
         chk({who, "_out_idx"}, idx, front);
         chk({who, "_out_last"}, last, (sz == 1) ? 1 : 0);
         chk({who, "_out_count"}, cnt, ecnt);
         chk({who, "_out_single"}, sgl, esgl);
      end else begin
         chk({who, "_idle_idx"}, idx, 0);
         chk({who, "_idle_last"}, last, 0);
         if (!rst_n) begin
            chk({who, "_rst_count"}, cnt, 0);
            chk({who, "_rst_single"}, sgl, 0);
         end
      end
   endtask

   always @(negedge clk) begin
      int fl, fm;
      fl = 0;
      fm = 0;
      if (mq_l.size() > 0) fl = mq_l[0];
      if (mq_m.size() > 0) fm = mq_m[0];
      cmp_dut("lsb", l_out_valid, l_in_ready, l_out_idx, l_out_last, l_out_single,
              l_out_count, mq_l.size(), fl, mcnt_l, msgl_l);
      cmp_dut("msb", m_out_valid, m_in_ready, m_out_idx, m_out_last, m_out_single,
              m_out_count, mq_m.size(), fm, mcnt_m, msgl_m);
   end

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   task automatic send(input logic [7:0] v);
      in_vec   = v;
      in_valid = 1'b1;
      nxt();
      in_valid = 1'b0;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n     = 1'b0;
      in_valid  = 1'b1;
      in_vec    = 8'hFF;
      out_ready = 1'b1;

      // Reset held with a full vector offered.
      repeat (3) begin
         smp();
         chk("rst_valid", l_out_valid, 0);
         chk("rst_ready", l_in_ready, 0);
         chk("rst_idx", l_out_idx, 0);
         chk("rst_count", m_out_count, 0);
      end
      @(posedge clk);
      #1;
      rst_n    = 1'b1;
      in_valid = 1'b0;
      smp();
      chk("post_rst_ready", l_in_ready, 1);
      chk("post_rst_ready_m", m_in_ready, 1);

      // Multi-hot.
      send(8'b0010_0100);
      smp();
      chk("mh_b0_idx", l_out_idx, 2);
      chk("mh_b0_last", l_out_last, 0);
      chk("mh_b0_count", l_out_count, 2);
      chk("mh_b0_single", l_out_single, 0);
      chk("mh_b0_idx_m", m_out_idx, 5);
      nxt();
      smp();
      chk("mh_b1_idx", l_out_idx, 5);
      chk("mh_b1_last", l_out_last, 1);
      chk("mh_b1_count", l_out_count, 2);
      chk("mh_b1_idx_m", m_out_idx, 2);
      nxt();
      smp();
      chk("mh_done", l_out_valid, 0);

      // One-hot then zero.
      send(8'b0000_0001);
      smp();
      chk("oh_idx", l_out_idx, 0);
      chk("oh_last", l_out_last, 1);
      chk("oh_single", l_out_single, 1);
      chk("oh_count", l_out_count, 1);
      chk("oh_idx_m", m_out_idx, 0);
      nxt();
      send(8'h00);
      smp();
      chk("zero_valid", l_out_valid, 0);
      chk("zero_ready", l_in_ready, 1);
      nxt();

      // Backpressure: MSB-first gives 7 then 0, LSB-first gives 0 then 7.
      out_ready = 1'b0;
      send(8'b1000_0001);
      for (int k = 0; k < 4; k++) begin
         if (k == 3) out_ready = 1'b1;
         smp();
         chk("bp_hold_m", m_out_idx, 7);
         chk("bp_hold_l", l_out_idx, 0);
         chk("bp_hold_last", m_out_last, 0);
         nxt();
      end
      smp();
      chk("bp_tail_m", m_out_idx, 0);
      chk("bp_tail_l", l_out_idx, 7);
      chk("bp_tail_last", m_out_last, 1);
      nxt();

      // Back-to-back: all-ones then a one-hot captured on the last beat.
      in_vec   = 8'hFF;
      in_valid = 1'b1;
      nxt();
      in_vec = 8'b0001_0000;
      for (int b = 0; b < 8; b++) begin
         smp();
         chk("b2b_idx", l_out_idx, b);
         chk("b2b_idx_m", m_out_idx, 7 - b);
         chk("b2b_count", l_out_count, 8);
         chk("b2b_ready", l_in_ready, (b == 7) ? 1 : 0);
         nxt();
      end
      in_valid = 1'b0;
      smp();
      chk("b2b_nobubble", l_out_valid, 1);
      chk("b2b_second_idx", l_out_idx, 4);
      chk("b2b_second_single", l_out_single, 1);
      chk("b2b_second_count", l_out_count, 1);
      nxt();
      smp();
      chk("b2b_done", l_out_valid, 0);

      // Reset mid-burst.
      send(8'hF0);
      smp();
      chk("mr_first", l_out_idx, 4);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mr_abort_l", l_out_valid, 0);
      chk("mr_abort_m", m_out_valid, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (3) begin
         smp();
         chk("mr_quiet", l_out_valid, 0);
         chk("mr_quiet_m", m_out_valid, 0);
         nxt();
      end
      send(8'h80);
      smp();
      chk("mr_new_idx", l_out_idx, 7);
      chk("mr_new_single", l_out_single, 1);
      chk("mr_new_idx_m", m_out_idx, 7);
      nxt();
      smp();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/prio_enc_stream.md
# prio_enc_stream

Parametrised sequential successor to the combinational 8-to-3 encoder. It captures an N-bit request vector through a valid/ready handshake and emits the binary index of every set bit, one per beat, in priority order. Each burst also reports its bit count and whether the captured vector was one-hot, the only case a strict N-to-log2(N) encoder can represent. It sits between request-collecting logic and any consumer that needs indices serialised rather than a single encoding that is undefined for multi-hot inputs.

## Interface
- N, 8, request vector width; integer ≥ 2.
- W, $clog2(N), index width; derived localparam, not overridable.
- LSB_FIRST, 1, priority direction. 1: lowest set bit first. 0: highest set bit first.

- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_vec  in  N  request vector; sampled on an in_valid & in_ready edge.
- in_valid  in  1  in_vec is valid.
- in_ready  out  1  block can capture a vector this cycle.
- out_idx  out  W  index of the current highest-priority pending bit.
- out_valid  out  1  out_idx is valid.
- out_ready  in  1  consumer accepts the current beat.
- out_last  out  1  current beat is the final beat of the burst.
- out_single  out  1  captured vector had exactly one bit set; held for the whole burst.
- out_count  out  W+1  popcount of the captured vector; held for the whole burst.

## Operation
- State machine has two states: IDLE and BURST. Registers are pending[N-1:0], count[W:0] and single.
- IDLE
  - in_ready=1 and out_valid=0.
  - On in_valid & in_ready with in_vec≠0: pending←in_vec, count←popcount(in_vec), single←(popcount==1). Go to BURST.
  - On in_valid & in_ready with in_vec=0: the vector is consumed and dropped. No beat is produced, state stays IDLE, and pending, count and single are unchanged.
- BURST
  - out_valid=1.
  - out_idx = index of the first set bit of pending, in the LSB_FIRST order.
  - out_last = (pending has exactly one bit set).
  - On out_valid & out_ready: clear bit out_idx in pending. If out_last, go to IDLE.
  - in_ready = out_valid & out_ready & out_last. A new vector can be captured in the same cycle the last beat is accepted. On that edge pending, count and single load the new vector; if the new vector is nonzero the state stays BURST.
  - in_valid is ignored when in_ready=0.
- out_idx, out_last, out_single and out_count are combinational functions of registers only. They are stable while out_valid & !out_ready. in_ready is the only output with a combinational path from an input (out_ready).
- out_idx, out_last, out_single and out_count are don't-care when out_valid=0. The RTL drives them from pending, which is cleared on burst completion, so out_idx=0 and out_last=0 in IDLE.

## Timing
- Reset value: while rst_n=0, state=IDLE, pending=0, count=0, single=0.
  - This gives out_valid=0, out_idx=0, out_last=0, out_single=0, out_count=0.
  - in_ready is forced to 0 while rst_n=0.
- Reset asserted mid-burst aborts the burst immediately. Remaining beats are lost.
- Latency: a vector captured at edge k produces its first beat with out_valid=1 in the cycle after edge k.
- A burst of a vector with popcount P takes P accepted beats and at least P cycles. With out_ready held at 1 it takes exactly P cycles.
- Back-to-back nonzero vectors with in_valid and out_ready both held at 1 give 100% out_valid occupancy with no bubble between bursts.
- Boundary cases:
  - An all-ones vector gives N beats; out_count=N needs the full W+1 bits.
  - A single-bit vector gives one beat with out_last=1 and out_single=1.
  - Bit N-1 and bit 0 are both reachable under both LSB_FIRST values.

## Test plan
- Reset: hold rst_n=0 for 3 cycles while driving in_valid=1 and in_vec=8'hFF. Require out_valid=0, in_ready=0, out_idx=0 and out_count=0. After release, require in_ready=1 in the first cycle.
- Multi-hot, N=8, LSB_FIRST=1, out_ready=1: send 8'b0010_0100. Require beats idx=2 (last=0) then idx=5 (last=1), with count=2 and single=0 on both.
- One-hot and zero: send 8'b0000_0001, then 8'h00. Require one beat idx=0, last=1, single=1, count=1. The zero vector must be accepted with no beat produced and in_ready must stay 1.
- Backpressure and order: LSB_FIRST=0, send 8'b1000_0001, hold out_ready=0 for 3 cycles, then release. Require idx=7 to be stable for 4 cycles, then idx=0 with last=1. Repeat with LSB_FIRST=1 and require the order 0 then 7.
- Back-to-back: send 8'hFF then 8'b0001_0000, with in_valid and out_ready held at 1. Require 8 beats (idx 0..7, count=8). On the idx=7 beat, in_ready=1 and the second vector is captured. The next cycle must be idx=4, single=1, with no bubble.
- Reset mid-burst: send 8'hF0 and pulse rst_n low after beat idx=4. Require out_valid=0 immediately, and no further beats after release until a new vector is captured.
